// File: rtl/ring_johnson_counter_if.sv
// Control and status bundle for ring_johnson_counter; the master drives controls, the slave returns state.
// WIDTH must match the WIDTH of the counter it is bound to.
interface ring_johnson_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             err;

    modport master (
        output en, dir, mode, load, load_val,
        input  count, wrap, err
    );

    modport slave (
        input  en, dir, mode, load, load_val,
        output count, wrap, err
    );
endinterface

// File: rtl/ring_johnson_counter.sv
// One-hot ring / Johnson counter with load, direction and wrap strobe; RING_SELF_CORRECT_EN adds illegal-state recovery.
// Latency: count, wrap and err are registered, visible one clk after the controls. Backpressure: none, en=0 holds state.
module ring_johnson_counter #(
    parameter int WIDTH    = 4,
    parameter int INIT_POS = WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    ring_johnson_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] RING_INIT = {{(WIDTH-1){1'b0}}, 1'b1} << INIT_POS;
    localparam logic [WIDTH-1:0] JOHN_INIT = '0;

    function automatic logic [WIDTH-1:0] init_of(input logic m);
        return m ? JOHN_INIT : RING_INIT;
    endfunction

    // Johnson differs from ring only by inverting the bit that wraps around.
    function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] c,
                                                  input logic             m,
                                                  input logic             d);
        logic [WIDTH-1:0] r;
        if (d)
            r = {c[WIDTH-2:0], c[WIDTH-1] ^ m};
        else
            r = {c[0] ^ m, c[WIDTH-1:1]};
        return r;
    endfunction

    logic [WIDTH-1:0] count_q;
    logic             mode_q;
    logic             wrap_q;
    logic [WIDTH-1:0] next_shift;
    logic             shift_hits_init;
    logic             mode_change;

    always_comb begin
        next_shift      = shift_of(count_q, mode_q, bus.dir);
        shift_hits_init = (next_shift == init_of(mode_q));
        mode_change     = (bus.mode != mode_q);
    end

`ifdef RING_SELF_CORRECT_EN
    logic illegal;
    logic err_q;

    // Legal Johnson words have at most one 0/1 boundary when read linearly.
    function automatic int johnson_edges(input logic [WIDTH-1:0] c);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH - 1; i++)
            if (c[i] != c[i+1])
                n++;
        return n;
    endfunction

    always_comb begin
        illegal = 1'b0;
        if (mode_q)
            illegal = (johnson_edges(count_q) > 1);
        else
            illegal = ($countones(count_q) != 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RING_INIT;
            mode_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (mode_change) begin
            count_q <= init_of(bus.mode);
            mode_q  <= bus.mode;
            wrap_q  <= 1'b0;
        end else if (bus.load) begin
            count_q <= bus.load_val;
            wrap_q  <= 1'b0;
        end else if (illegal) begin
            count_q <= init_of(mode_q);
            wrap_q  <= 1'b0;
            err_q   <= 1'b1;
        end else if (bus.en) begin
            count_q <= next_shift;
            wrap_q  <= shift_hits_init;
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign bus.err = err_q;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RING_INIT;
            mode_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (mode_change) begin
            count_q <= init_of(bus.mode);
            mode_q  <= bus.mode;
            wrap_q  <= 1'b0;
        end else if (bus.load) begin
            count_q <= bus.load_val;
            wrap_q  <= 1'b0;
        end else if (bus.en) begin
            count_q <= next_shift;
            wrap_q  <= shift_hits_init;
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign bus.err = 1'b0;
`endif

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed bench for ring_johnson_counter (WIDTH=4, INIT_POS=3) with hand-computed expectations.
module tb_ring_johnson_counter;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    ring_johnson_counter_if #(.WIDTH(4)) bus ();

    ring_johnson_counter #(.WIDTH(4), .INIT_POS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cw(input string tag, input logic [3:0] cnt, input logic wr);
        check({tag, "_count"}, {28'd0, bus.count}, {28'd0, cnt});
        check({tag, "_wrap"}, {31'd0, bus.wrap}, {31'd0, wr});
    endtask

    logic [3:0] ring_seq [4];
    logic [3:0] john_seq [8];
    logic       err_exp;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        ring_seq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        john_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                     4'b1110, 4'b1100, 4'b1000, 4'b0000};
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.dir      = 1'b0;
        bus.mode     = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'b0000;

        step();
        expect_cw("reset", 4'b1000, 1'b0);
        check("reset_err", {31'd0, bus.err}, 32'd0);

        // Ring, dir=0: wrap only when landing back on 1000.
        reset  = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_cw($sformatf("ring%0d", i), ring_seq[i], i == 3);
        end
        step();
        expect_cw("ring_after_wrap", 4'b0100, 1'b0);

        // Switch to Johnson, dir=1: re-init to 0000, then full 8-step period.
        bus.mode = 1'b1;
        bus.dir  = 1'b1;
        step();
        expect_cw("mode_switch", 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            expect_cw($sformatf("john%0d", i), john_seq[i], i == 7);
        end

        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_cw($sformatf("hold%0d", i), 4'b0000, 1'b0);
        end

        bus.load     = 1'b1;
        bus.load_val = 4'b1010;
        bus.en       = 1'b1;
        step();
        expect_cw("load_beats_shift", 4'b1010, 1'b0);
        bus.load = 1'b0;
        bus.en   = 1'b0;

        // Back to ring: mode change beats everything and restarts at 1000.
        bus.mode = 1'b0;
        bus.dir  = 1'b0;
        step();
        expect_cw("back_to_ring", 4'b1000, 1'b0);
        bus.en = 1'b1;
        step();
        expect_cw("ring_a", 4'b0100, 1'b0);
        step();
        expect_cw("ring_b", 4'b0010, 1'b0);

        reset = 1'b1;
        #2;
        expect_cw("async_reset", 4'b1000, 1'b0);
        reset = 1'b0;
        step();
        expect_cw("resume", 4'b0100, 1'b0);

        // Direction flip lands on INIT from the other side.
        bus.dir = 1'b1;
        step();
        expect_cw("dir1_wrap", 4'b1000, 1'b1);
        step();
        expect_cw("dir1_next", 4'b0001, 1'b0);

        bus.en       = 1'b0;
        bus.dir      = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'b0110;
        step();
        expect_cw("load_illegal", 4'b0110, 1'b0);
        bus.load = 1'b0;
        bus.en   = 1'b1;
`ifdef RING_SELF_CORRECT_EN
        err_exp = 1'b1;
        step();
        expect_cw("correct", 4'b1000, 1'b0);
        check("err_set", {31'd0, bus.err}, {31'd0, err_exp});
        step();
        expect_cw("after_correct", 4'b0100, 1'b0);
        check("err_sticky", {31'd0, bus.err}, {31'd0, err_exp});
`else
        err_exp = 1'b0;
        step();
        expect_cw("no_correct", 4'b0011, 1'b0);
        check("err_zero", {31'd0, bus.err}, {31'd0, err_exp});
        step();
        expect_cw("no_correct2", 4'b1001, 1'b0);
        check("err_zero2", {31'd0, bus.err}, {31'd0, err_exp});
`endif

        // mode=1 held through reset release: first edge performs the Johnson re-init.
        reset    = 1'b1;
        bus.mode = 1'b1;
        step();
        expect_cw("reset_mode1", 4'b1000, 1'b0);
        check("reset_clears_err", {31'd0, bus.err}, 32'd0);
        reset = 1'b0;
        step();
        expect_cw("release_mode1", 4'b0000, 1'b0);
        step();
        expect_cw("release_mode1_shift", 4'b1000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
